vx_axi_wr_burst_arb: RTL and testbench
======================================

Name: vx_axi_wr_burst_arb

Overview:
- N-input to 1-output AXI4 write-path arbiter for memory-side traffic.
- Arbitrates AW bursts round-robin and tags each output AWID with the source index.
- Records grant order in a W-route FIFO, so W beats follow AW grant order and each burst stays atomic until WLAST.
- Routes B responses back to the source by the ID tag. Sits between cache/DMA write masters and the single AXI memory port.

Parameters:
- NUM_INPUTS, 2, number of slave ports (>=1).
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 512, AXI data width; strobe is DATA_WIDTH/8.
- ID_WIDTH, 8, input AWID/BID width.
- W_FIFO_DEPTH, 4, outstanding AW grants whose W bursts are not yet complete (power of 2, >=2).
- SEL_BITS, log2 of NUM_INPUTS (0 when NUM_INPUTS=1), derived; output ID width is ID_WIDTH+SEL_BITS.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- s_awvalid/s_awready  in/out  NUM_INPUTS  per-input AW handshake.
- s_awaddr  in  NUM_INPUTS*ADDR_WIDTH  per-input AW address.
- s_awid  in  NUM_INPUTS*ID_WIDTH  per-input AW ID.
- s_awlen  in  NUM_INPUTS*8  per-input burst length.
- s_awsize  in  NUM_INPUTS*3  per-input beat size.
- s_awburst  in  NUM_INPUTS*2  per-input burst type.
- s_wvalid/s_wready/s_wlast  in/out/in  NUM_INPUTS  per-input W handshake and last-beat flag.
- s_wdata  in  NUM_INPUTS*DATA_WIDTH  per-input write data.
- s_wstrb  in  NUM_INPUTS*DATA_WIDTH/8  per-input write strobes.
- s_bvalid/s_bready  out/in  NUM_INPUTS  per-input B handshake.
- s_bid  out  NUM_INPUTS*ID_WIDTH  per-input response ID.
- s_bresp  out  NUM_INPUTS*2  per-input response code.
- m_awvalid/m_awready  out/in  1  output AW handshake.
- m_awaddr  out  ADDR_WIDTH  output AW address.
- m_awid  out  ID_WIDTH+SEL_BITS  output AW ID (tagged).
- m_awlen  out  8  output burst length.
- m_awsize  out  3  output beat size.
- m_awburst  out  2  output burst type.
- m_wvalid/m_wready/m_wlast  out/in/out  1  output W handshake and last-beat flag.
- m_wdata  out  DATA_WIDTH  output write data.
- m_wstrb  out  DATA_WIDTH/8  output write strobes.
- m_bvalid/m_bready  in/out  1  output B handshake.
- m_bid  in  ID_WIDTH+SEL_BITS  output response ID (tagged).
- m_bresp  in  2  output response code.
- wlast_err  out  1  protocol-error flag (see Optional Feature).

Behaviour:
- Reset (async assert, sync deassert): rr pointer=0, grant lock clear, W FIFO empty, beat counter 0, wlast_err=0. While reset_n=0: m_awvalid=0, m_wvalid=0, s_bvalid=0, all s_*ready=0, m_bready=0.
- AW arbitration, state IDLE/LOCKED:
  - IDLE: when the W FIFO is not full and any s_awvalid is set, pick the first requester at or after the rr pointer. Drive m_awvalid=1 with that input's fields, zero-cycle latency. Go to LOCKED if m_awready=0.
  - LOCKED: the same input is held and fields stay stable until m_awready.
  - On handshake: s_awready[sel]=1, push sel into the W FIFO, rr pointer=sel+1 (wraps modulo NUM_INPUTS), return to IDLE.
- m_awvalid never depends on m_awready.
- m_awid = {s_awid[sel], sel}, with sel in the low SEL_BITS. When NUM_INPUTS=1, m_awid = s_awid.
- W FIFO full: no AW grant, all s_awready=0. A push is blocked at full even if a pop happens in the same cycle.
- W routing, head h = FIFO head:
  - m_wvalid = !empty && s_wvalid[h]; m_wdata/m_wstrb/m_wlast from input h.
  - s_wready[i] = !empty && i==h && m_wready.
  - Pop on a W handshake with wlast=1.
  - FIFO empty: m_wvalid=0 and all s_wready=0; W data arriving before its AW is stalled.
  - Same-cycle push and pop when not full: both occur, count unchanged.
- B routing: s_bvalid[i] = m_bvalid && m_bid[SEL_BITS-1:0]==i; s_bid[i] = m_bid[ID_WIDTH+SEL_BITS-1:SEL_BITS]; s_bresp[i] = m_bresp; m_bready = s_bready[selected]. Zero latency, no storage.
- Reset mid-burst: FIFO and lock are discarded; no stale W route survives.

Optional Feature:
- Macro: VX_AXI_WR_ARB_WLAST_CHECK_EN.
- When defined: a W FIFO entry also stores awlen; an 8-bit beat counter counts W handshakes of the head burst.
  - wlast_err is sticky; it is set when wlast=1 arrives with count!=awlen, or wlast=0 arrives with count==awlen. Cleared only by reset.
  - The counter is cleared on pop.
- When undefined: no awlen storage, no counter, wlast_err tied 0.

Decomposition:
- Package vx_axi_arb_pkg: burst-type and resp constants (FIXED/INCR/WRAP, OKAY/SLVERR), SEL_BITS helper function, W FIFO entry typedef {sel, awlen}.
- One sub-module, vx_axi_wr_route_fifo: the grant-order FIFO with push/pop/full/empty and head output, instantiated once.

Test Plan:
- Both inputs issue AW simultaneously (id 0x05 and 0x07, awlen 3) with m_awready=1 -> input0 granted first with m_awid=0x0A, then input1 with 0x0F; W beats output as 4 of input0 then 4 of input1.
- Input1's W arrives 5 cycles before input0's while grant order is 0 then 1 -> s_wready[1]=0 until input0's wlast beat completes.
- W_FIFO_DEPTH=4, m_wready=0, 5 AW requests -> 4 accepted, 5th s_awready=0 until the first wlast pop.
- m_bvalid with m_bid=0x0F, bresp=2 -> s_bvalid[1]=1, s_bid[1]=0x07, s_bresp[1]=2; m_bready follows s_bready[1].
- m_awready held 0 for 3 cycles while input0 is granted and input1 raises valid -> m_awaddr stable, grant stays input0.
- With WLAST_CHECK_EN, awlen=3 and wlast on the 2nd beat -> wlast_err=1, sticky until reset_n=0.

Source files
------------

// File: rtl/vx_axi_arb_pkg.sv
// vx_axi_arb_pkg: shared AXI write-arbiter constants, select-width helper and W route entry type
package vx_axi_arb_pkg;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int MAX_SEL_BITS = 8;
  function automatic int sel_bits(input int n);
    return n > 1 ? $clog2(n) : 0;
  endfunction
  typedef struct packed {
    logic [MAX_SEL_BITS-1:0] sel;
    logic [7:0]              awlen;
  } wroute_t;
endpackage

// File: rtl/vx_axi_wr_burst_arb_if.sv
// vx_axi_wr_burst_arb_if: flattened AXI4 write-channel bundle for N ports (AW, W, B)
interface vx_axi_wr_burst_arb_if #(
  parameter int N          = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 8
);
  logic [N-1:0]              awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [N*ADDR_WIDTH-1:0]   awaddr;
  logic [N*ID_WIDTH-1:0]     awid, bid;
  logic [N*8-1:0]            awlen;
  logic [N*3-1:0]            awsize;
  logic [N*2-1:0]            awburst, bresp;
  logic [N*DATA_WIDTH-1:0]   wdata;
  logic [N*DATA_WIDTH/8-1:0] wstrb;
  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst, wvalid, wdata, wstrb, wlast, bready,
    input  awready, wready, bvalid, bid, bresp
  );
  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst, wvalid, wdata, wstrb, wlast, bready,
    output awready, wready, bvalid, bid, bresp
  );
endinterface

// File: rtl/vx_axi_wr_route_fifo.sv
// vx_axi_wr_route_fifo: grant-order FIFO naming the input that owns each pending W burst
module vx_axi_wr_route_fifo
  import vx_axi_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset_n,
  input  logic    push,
  input  logic    pop,
  input  wroute_t din,
  output wroute_t head,
  output logic    full,
  output logic    empty
);
  localparam int PW = $clog2(DEPTH);
  wroute_t mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic do_push, do_pop;
  assign full = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
  // a push at full is dropped even when a pop frees a slot in the same cycle
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/vx_axi_wr_burst_arb.sv
// vx_axi_wr_burst_arb: N:1 AXI4 write arbiter - round-robin AW, grant-ordered W, ID-routed B.
// Define VX_AXI_WR_ARB_WLAST_CHECK_EN to flag misplaced WLAST on the sticky wlast_err output.
module vx_axi_wr_burst_arb
  import vx_axi_arb_pkg::*;
#(
  parameter int NUM_INPUTS   = 2,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 512,
  parameter int ID_WIDTH     = 8,
  parameter int W_FIFO_DEPTH = 4,
  parameter int SEL_BITS     = sel_bits(NUM_INPUTS)
) (
  input  logic clk,
  input  logic reset_n,
  vx_axi_wr_burst_arb_if.slave  s,
  vx_axi_wr_burst_arb_if.master m,
  output logic wlast_err
);
  localparam int SW = SEL_BITS > 0 ? SEL_BITS : 1;
  localparam int SBW = DATA_WIDTH / 8;
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state;
  logic [SW-1:0] rr, lock_sel, pick, sel, h, bsel;
  logic found, full, empty, aw_hs, w_hs, pop;
  logic [ID_WIDTH-1:0] awid_sel;
  wroute_t head, din;
  int idx;
  always_comb begin
    pick = '0;
    found = 1'b0;
    idx = 0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      idx = (int'(rr) + i) % NUM_INPUTS;
      if (!found && s.awvalid[SW'(idx)]) begin
        pick = SW'(idx);
        found = 1'b1;
      end
    end
  end
  assign sel = state == LOCKED ? lock_sel : pick;
  // once presented, a locked request stays up regardless of m_awready or room
  assign m.awvalid = reset_n && (state == LOCKED || (!full && found));
  assign aw_hs = m.awvalid && m.awready;
  assign s.awready = aw_hs ? NUM_INPUTS'(1) << sel : '0;
  assign m.awaddr = s.awaddr[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
  assign m.awlen = s.awlen[int'(sel)*8 +: 8];
  assign m.awsize = s.awsize[int'(sel)*3 +: 3];
  assign m.awburst = s.awburst[int'(sel)*2 +: 2];
  assign awid_sel = s.awid[int'(sel)*ID_WIDTH +: ID_WIDTH];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      rr <= '0;
      lock_sel <= '0;
    end else if (aw_hs) begin
      state <= IDLE;
      rr <= (int'(sel) == NUM_INPUTS - 1) ? '0 : sel + SW'(1);
    end else if (m.awvalid) begin
      state <= LOCKED;
      lock_sel <= sel;
    end
  end
  if (SEL_BITS == 0) begin : g_single
    assign m.awid = awid_sel;
    assign bsel = '0;
    assign s.bid = m.bid;
  end else begin : g_tagged
    assign m.awid = {awid_sel, sel};
    assign bsel = m.bid[SEL_BITS-1:0];
    assign s.bid = {NUM_INPUTS{m.bid[ID_WIDTH+SEL_BITS-1:SEL_BITS]}};
  end
  assign s.bvalid = (reset_n && m.bvalid) ? NUM_INPUTS'(1) << bsel : '0;
  assign s.bresp = {NUM_INPUTS{m.bresp}};
  assign m.bready = reset_n && s.bready[bsel];
  assign din.sel = MAX_SEL_BITS'(sel);
`ifdef VX_AXI_WR_ARB_WLAST_CHECK_EN
  assign din.awlen = m.awlen;
`else
  assign din.awlen = '0;
`endif
  vx_axi_wr_route_fifo #(.DEPTH(W_FIFO_DEPTH)) u_route (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (aw_hs),
    .pop     (pop),
    .din     (din),
    .head    (head),
    .full    (full),
    .empty   (empty)
  );
  assign h = head.sel[SW-1:0];
  assign m.wvalid = !empty && s.wvalid[h];
  assign m.wdata = s.wdata[int'(h)*DATA_WIDTH +: DATA_WIDTH];
  assign m.wstrb = s.wstrb[int'(h)*SBW +: SBW];
  assign m.wlast = s.wlast[h];
  assign s.wready = (!empty && m.wready) ? NUM_INPUTS'(1) << h : '0;
  assign w_hs = m.wvalid && m.wready;
  assign pop = w_hs && m.wlast;
`ifdef VX_AXI_WR_ARB_WLAST_CHECK_EN
  logic [7:0] beat_cnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt <= '0;
      wlast_err <= 1'b0;
    end else if (w_hs) begin
      if (m.wlast != (beat_cnt == head.awlen)) wlast_err <= 1'b1;
      beat_cnt <= m.wlast ? 8'd0 : beat_cnt + 8'd1;
    end
  end
`else
  assign wlast_err = 1'b0;
`endif
  logic unused_head;
  assign unused_head = ^head;
endmodule

// File: tb/tb_vx_axi_wr_burst_arb.sv
// tb_vx_axi_wr_burst_arb: scoreboard bench for the 2-input AXI write arbiter
module tb_vx_axi_wr_burst_arb;
  import vx_axi_arb_pkg::*;
  typedef struct packed { logic [31:0] addr; logic [7:0] id; logic [7:0] len; } aw_t;
  typedef struct packed { logic [31:0] data; logic last; logic src; } wb_t;
  typedef struct packed { logic [31:0] addr; logic [8:0] id; logic [7:0] len; } exp_aw_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic wlast_err;
  int total = 0, bad = 0, cyc = 0, open_n = 0, tag = 0;
  aw_t src_aw [2][$];
  wb_t src_w [2][$];
  int w_start [2];
  exp_aw_t exp_aw [$];
  wb_t exp_w [$];
  vx_axi_wr_burst_arb_if #(.N(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(8)) s_if ();
  vx_axi_wr_burst_arb_if #(.N(1), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(9)) m_if ();
  vx_axi_wr_burst_arb #(
    .NUM_INPUTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(8), .W_FIFO_DEPTH(4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s         (s_if),
    .m         (m_if),
    .wlast_err (wlast_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", name, got, exp, cyc);
    end
  endtask
  task automatic drive();
    aw_t a;
    wb_t b;
    for (int i = 0; i < 2; i++) begin
      a = src_aw[i].size() > 0 ? src_aw[i][0] : '0;
      b = src_w[i].size() > 0 ? src_w[i][0] : '0;
      s_if.awvalid[i] = src_aw[i].size() > 0;
      s_if.awaddr[i*32 +: 32] = a.addr;
      s_if.awid[i*8 +: 8] = a.id;
      s_if.awlen[i*8 +: 8] = a.len;
      s_if.awsize[i*3 +: 3] = 3'd2;
      s_if.awburst[i*2 +: 2] = BURST_INCR;
      s_if.wvalid[i] = src_w[i].size() > 0 && cyc >= w_start[i];
      s_if.wdata[i*32 +: 32] = b.data;
      s_if.wlast[i] = b.last;
      s_if.wstrb[i*4 +: 4] = 4'hF;
    end
  endtask
  // expected AW/W order is the order bursts are queued here, i.e. the round-robin grant order
  task automatic add_burst(input int i, input logic [31:0] addr, input logic [7:0] id,
                           input logic [7:0] len, input int nb);
    exp_aw_t e;
    wb_t b;
    src_aw[i].push_back('{addr, id, len});
    e.addr = addr;
    e.id = {id, 1'(i)};
    e.len = len;
    exp_aw.push_back(e);
    for (int k = 0; k < nb; k++) begin
      b.data = {8'(8'hD0 + i), 8'(tag), 8'(k), 8'h5A};
      b.last = (k == nb - 1);
      b.src = 1'(i);
      src_w[i].push_back(b);
      exp_w.push_back(b);
    end
    tag++;
  endtask
  task automatic tick();
    logic [1:0] exp_wr;
    exp_aw_t e;
    wb_t b;
    @(negedge clk);
    exp_wr = (open_n > 0 && m_if.wready && exp_w.size() > 0) ? 2'(1) << exp_w[0].src : 2'b00;
    if (reset_n) chk("s_wready", s_if.wready, exp_wr);
    if (m_if.awvalid && m_if.awready) begin
      chk("aw_fifo_room", open_n < 4, 1);
      chk("aw_expected", exp_aw.size() > 0, 1);
      if (exp_aw.size() > 0) begin
        e = exp_aw.pop_front();
        chk("m_awid", m_if.awid, e.id);
        chk("m_awaddr", m_if.awaddr, e.addr);
        chk("m_awlen", m_if.awlen, e.len);
      end
      open_n++;
    end
    if (m_if.wvalid && m_if.wready) begin
      chk("w_expected", exp_w.size() > 0, 1);
      if (exp_w.size() > 0) begin
        b = exp_w.pop_front();
        chk("m_wdata", m_if.wdata, b.data);
        chk("m_wlast", m_if.wlast, b.last);
      end
      if (m_if.wlast) open_n--;
    end
    for (int i = 0; i < 2; i++) begin
      if (s_if.awvalid[i] && s_if.awready[i]) void'(src_aw[i].pop_front());
      if (s_if.wvalid[i] && s_if.wready[i]) void'(src_w[i].pop_front());
    end
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask
  task automatic run(input int max);
    int n = 0;
    while ((exp_aw.size() > 0 || exp_w.size() > 0) && n < max) begin
      tick();
      n++;
    end
    chk("drained", exp_aw.size() + exp_w.size(), 0);
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      src_aw[i].delete();
      src_w[i].delete();
      w_start[i] = 0;
    end
    exp_aw.delete();
    exp_w.delete();
    open_n = 0;
    m_if.awready = 1'b0;
    m_if.wready = 1'b0;
    m_if.bvalid = 1'b0;
    m_if.bid = '0;
    m_if.bresp = RESP_OKAY;
    s_if.bready = '0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask
  initial begin
    do_reset();
    reset_n = 1'b0;
    s_if.awvalid = 2'b11;
    s_if.wvalid = 2'b11;
    s_if.bready = 2'b11;
    m_if.awready = 1'b1;
    m_if.wready = 1'b1;
    m_if.bvalid = 1'b1;
    m_if.bid = 9'h0F;
    #2;
    chk("rst_m_awvalid", m_if.awvalid, 0);
    chk("rst_m_wvalid", m_if.wvalid, 0);
    chk("rst_s_awready", s_if.awready, 0);
    chk("rst_s_wready", s_if.wready, 0);
    chk("rst_s_bvalid", s_if.bvalid, 0);
    chk("rst_m_bready", m_if.bready, 0);
    chk("rst_wlast_err", wlast_err, 0);
    // simultaneous requests: input0 first, W bursts 4+4 in grant order
    do_reset();
    m_if.awready = 1'b1;
    m_if.wready = 1'b1;
    add_burst(0, 32'h0000_1000, 8'h05, 8'd3, 4);
    add_burst(1, 32'h0000_2000, 8'h07, 8'd3, 4);
    drive();
    run(60);
    chk("wlast_err_clean", wlast_err, 0);
    // input1 W arrives 5 cycles ahead of input0 W but must wait for it
    do_reset();
    m_if.awready = 1'b1;
    m_if.wready = 1'b1;
    w_start[1] = cyc;
    w_start[0] = cyc + 5;
    add_burst(0, 32'h0000_3000, 8'h11, 8'd3, 4);
    add_burst(1, 32'h0000_4000, 8'h12, 8'd3, 4);
    drive();
    repeat (3) tick();
    chk("early_w1_stalled", s_if.wready[1], 0);
    chk("early_m_wvalid", m_if.wvalid, 0);
    run(60);
    // W FIFO full: 4 grants accepted, 5th held until the first WLAST pop
    do_reset();
    m_if.awready = 1'b1;
    add_burst(0, 32'h0000_5000, 8'h20, 8'd1, 2);
    add_burst(1, 32'h0000_5100, 8'h21, 8'd1, 2);
    add_burst(0, 32'h0000_5200, 8'h22, 8'd1, 2);
    add_burst(1, 32'h0000_5300, 8'h23, 8'd1, 2);
    add_burst(0, 32'h0000_5400, 8'h24, 8'd1, 2);
    drive();
    repeat (8) tick();
    chk("full_aw_granted", 5 - exp_aw.size(), 4);
    chk("full_s_awready", s_if.awready, 0);
    chk("full_m_awvalid", m_if.awvalid, 0);
    m_if.wready = 1'b1;
    run(60);
    // B routing by the low ID bit
    do_reset();
    m_if.bvalid = 1'b1;
    m_if.bid = 9'h0F;
    m_if.bresp = RESP_SLVERR;
    s_if.bready = 2'b10;
    #1;
    chk("b1_valid", s_if.bvalid, 2'b10);
    chk("b1_id", s_if.bid[15:8], 8'h07);
    chk("b1_resp", s_if.bresp[3:2], 2'd2);
    chk("b1_ready", m_if.bready, 1);
    s_if.bready = 2'b01;
    #1;
    chk("b1_not_ready", m_if.bready, 0);
    m_if.bid = 9'h0A;
    m_if.bresp = RESP_OKAY;
    #1;
    chk("b0_valid", s_if.bvalid, 2'b01);
    chk("b0_id", s_if.bid[7:0], 8'h05);
    chk("b0_ready", m_if.bready, 1);
    m_if.bvalid = 1'b0;
    #1;
    chk("b_idle", s_if.bvalid, 2'b00);
    // lock: rr points at input1, yet the stalled input0 grant is held
    do_reset();
    m_if.awready = 1'b1;
    m_if.wready = 1'b1;
    add_burst(0, 32'h0000_0100, 8'h01, 8'd0, 1);
    drive();
    run(20);
    m_if.awready = 1'b0;
    add_burst(0, 32'h0000_6000, 8'h22, 8'd0, 1);
    drive();
    tick();
    add_burst(1, 32'h0000_7000, 8'h33, 8'd0, 1);
    drive();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("lock_awaddr", m_if.awaddr, 32'h0000_6000);
      chk("lock_awid", m_if.awid, 9'h044);
      chk("lock_s_awready", s_if.awready, 0);
    end
    m_if.awready = 1'b1;
    run(30);
    // reset mid-burst discards the route
    do_reset();
    m_if.awready = 1'b1;
    m_if.wready = 1'b1;
    add_burst(0, 32'h0000_8000, 8'h40, 8'd3, 4);
    drive();
    repeat (2) tick();
    do_reset();
    m_if.wready = 1'b1;
    s_if.wvalid = 2'b11;
    #1;
    chk("rst_mid_m_wvalid", m_if.wvalid, 0);
    chk("rst_mid_s_wready", s_if.wready, 0);
    // awlen=3 burst ending on its 2nd beat
    do_reset();
    m_if.awready = 1'b1;
    m_if.wready = 1'b1;
    add_burst(0, 32'h0000_9000, 8'h09, 8'd3, 2);
    drive();
    run(20);
`ifdef VX_AXI_WR_ARB_WLAST_CHECK_EN
    chk("wlast_err_set", wlast_err, 1);
    repeat (3) tick();
    chk("wlast_err_sticky", wlast_err, 1);
    do_reset();
    chk("wlast_err_cleared", wlast_err, 0);
`else
    chk("wlast_err_tied", wlast_err, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
